// File: rtl/fp16_pkg.sv
// Shared binary16 constants, FSM state encoding and operand classification helpers
// for the fp16 divider.
package fp16_pkg;

  localparam int unsigned EXP_BIAS  = 15;
  localparam logic [4:0]  EXP_MAX   = 5'h1F;
  localparam logic [15:0] QNAN      = 16'h7FFF;
  localparam logic [15:0] POS_INF   = 16'h7C00;
  localparam int unsigned DIV_STEPS = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_DIV,
    S_ROUND
  } state_t;

  function automatic logic is_zero(input logic [15:0] x);
    return (x & 16'h7FFF) == 16'h0000;
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x & 16'h7FFF) == POS_INF;
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x & 16'h7FFF) > POS_INF;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// 11-bit leading-zero counter used to left-normalize subnormal significands.
module fp16_lzc (
  input  logic [10:0] i_val,
  output logic [3:0]  o_cnt
);

  // Later (higher) set bits override earlier ones, so the MSB-most one wins.
  always_comb begin
    o_cnt = 4'd11;
    for (int unsigned i = 0; i < 11; i++) begin
      if (i_val[i]) o_cnt = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_divider.sv
// Multi-cycle binary16 divider: special operands resolve in one cycle, normal
// operands go NORM -> 13-step restoring DIV -> ROUND with round-to-nearest-even.
module fp16_divider
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] result,
  output logic        dz
);

  localparam logic signed [6:0] BIAS7    = 7'(EXP_BIAS);
  localparam logic [3:0]        DIV_LAST = 4'(DIV_STEPS - 1);

  state_t r_state, w_next;

  logic [15:0]        r_a, r_b;
  logic [12:0]        r_rem;
  logic [10:0]        r_div;
  logic [12:0]        r_q;
  logic signed [6:0]  r_exp;
  logic [3:0]         r_cnt;
  logic [15:0]        r_result;
  logic               r_out_valid;
  logic               r_dz;

  logic               w_a_zero, w_a_inf, w_a_nan;
  logic               w_b_zero, w_b_inf, w_b_nan;
  logic               w_special, w_sign_in;
  logic [15:0]        w_spec_res;
  logic               w_spec_dz;

  logic [10:0]        w_ma, w_mb, w_mna, w_mnb;
  logic [3:0]         w_lza, w_lzb;
  logic signed [6:0]  w_eaeff, w_ebeff, w_e0;
  logic               w_lt;

  logic [12:0]        w_trial, w_keep;
  logic               w_ge;

  logic               w_e_le0;
  logic signed [6:0]  w_diff, w_efin;
  logic [3:0]         w_sh;
  logic [12:0]        w_qs;
  logic [15:0]        w_mask;
  logic               w_lost, w_sticky, w_inc;
  logic [10:0]        w_mant;
  logic [11:0]        w_msum;
  logic [15:0]        w_res;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign dz        = r_dz;

  // Operand classification and special-case results
  always_comb begin
    w_a_zero   = is_zero(a);
    w_a_inf    = is_inf(a);
    w_a_nan    = is_nan(a);
    w_b_zero   = is_zero(b);
    w_b_inf    = is_inf(b);
    w_b_nan    = is_nan(b);
    w_sign_in  = a[15] ^ b[15];
    w_special  = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;
    w_spec_res = QNAN;
    w_spec_dz  = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_spec_res = QNAN;
    end else if (w_b_zero && !w_a_inf) begin
      w_spec_res = {w_sign_in, POS_INF[14:0]};
      w_spec_dz  = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {w_sign_in, POS_INF[14:0]};
    end else begin
      w_spec_res = {w_sign_in, 15'd0};
    end
  end

  fp16_lzc u_lzc_a (.i_val(w_ma), .o_cnt(w_lza));
  fp16_lzc u_lzc_b (.i_val(w_mb), .o_cnt(w_lzb));

  // Normalization: subnormals get shifted up to a hidden-one significand
  always_comb begin
    w_ma    = {|r_a[14:10], r_a[9:0]};
    w_mb    = {|r_b[14:10], r_b[9:0]};
    w_mna   = w_ma << w_lza;
    w_mnb   = w_mb << w_lzb;
    w_eaeff = (r_a[14:10] == 5'd0) ? (7'sd1 - signed'({3'b000, w_lza}))
                                   : signed'({2'b00, r_a[14:10]});
    w_ebeff = (r_b[14:10] == 5'd0) ? (7'sd1 - signed'({3'b000, w_lzb}))
                                   : signed'({2'b00, r_b[14:10]});
    w_e0    = w_eaeff - w_ebeff + BIAS7;
    w_lt    = (w_mna < w_mnb);
  end

  always_comb begin
    w_trial = r_rem - {2'b00, r_div};
    w_ge    = (r_rem >= {2'b00, r_div});
    w_keep  = w_ge ? w_trial : r_rem;
  end

  // Rounding: denormalizing right shift folds lost bits into sticky, and a
  // subnormal that rounds into bit10 naturally yields exponent field 1.
  always_comb begin
    w_e_le0  = (r_exp <= 7'sd0);
    w_diff   = 7'sd1 - r_exp;
    w_sh     = 4'd0;
    if (w_e_le0) w_sh = (w_diff > 7'sd14) ? 4'd14 : w_diff[3:0];
    w_qs     = r_q >> w_sh;
    w_mask   = (16'd1 << w_sh) - 16'd1;
    w_lost   = |({3'b000, r_q} & w_mask);
    w_sticky = (r_rem != 13'd0) | w_lost;
    w_mant   = w_qs[12:2];
    w_inc    = w_qs[1] & (w_qs[0] | w_sticky | w_mant[0]);
    w_msum   = {1'b0, w_mant} + {11'd0, w_inc};
    w_efin   = r_exp + signed'({6'd0, w_msum[11]});
    w_res    = '0;
    if (w_e_le0) begin
      w_res = {r_a[15] ^ r_b[15], 4'd0, w_msum[10], w_msum[9:0]};
    end else if (w_efin >= 7'sd31) begin
      w_res = {r_a[15] ^ r_b[15], EXP_MAX, 10'd0};
    end else begin
      w_res = {r_a[15] ^ r_b[15], w_efin[4:0], w_msum[9:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid && !w_special) w_next = S_NORM;
      S_NORM:  w_next = S_DIV;
      S_DIV:   if (r_cnt == DIV_LAST) w_next = S_ROUND;
      S_ROUND: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_exp       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_special) begin
              r_result    <= w_spec_res;
              r_dz        <= w_spec_dz;
              r_out_valid <= 1'b1;
            end else begin
              r_a <= a;
              r_b <= b;
            end
          end
        end
        S_NORM: begin
          r_rem <= w_lt ? {1'b0, w_mna, 1'b0} : {2'b00, w_mna};
          r_div <= w_mnb;
          r_exp <= w_lt ? (w_e0 - 7'sd1) : w_e0;
          r_q   <= '0;
          r_cnt <= '0;
        end
        S_DIV: begin
          r_rem <= w_keep << 1;
          r_q   <= {r_q[11:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        S_ROUND: begin
          r_result    <= w_res;
          r_dz        <= 1'b0;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_divider.sv
// Directed-vector bench for fp16_divider: table of operand pairs with expected
// results and latencies, plus handshake and reset-abort sequences.
module tb_fp16_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, dz;
  logic [15:0] result;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        dz;
    int unsigned lat;
  } vec_t;

  vec_t vecs[20];

  fp16_divider dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .result   (result),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Counts falling edges after the accept edge until out_valid is seen; drops in_valid.
  task automatic wait_result(output int unsigned lat);
    lat = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int unsigned lat;
    @(negedge clk);
    a = v.a;
    b = v.b;
    in_valid = 1'b1;
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    wait_result(lat);
    check({name, " latency"}, lat, v.lat);
    check({name, " result"}, {16'd0, result}, {16'd0, v.res});
    check({name, " dz"}, {31'd0, dz}, {31'd0, v.dz});
    @(negedge clk);
    check({name, " pulse"}, {31'd0, out_valid}, 32'd0);
    check({name, " hold"}, {16'd0, result}, {16'd0, v.res});
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    int unsigned busy_ready;
    int unsigned stray;

    vecs[0]  = '{16'h3C00, 16'h4200, 16'h3555, 1'b0, 16};
    vecs[1]  = '{16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1};
    vecs[2]  = '{16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1};
    vecs[3]  = '{16'h7C00, 16'h7C00, 16'h7FFF, 1'b0, 1};
    vecs[4]  = '{16'hBC00, 16'h7C00, 16'h8000, 1'b0, 1};
    vecs[5]  = '{16'h7BFF, 16'h3800, 16'h7C00, 1'b0, 16};
    vecs[6]  = '{16'h0400, 16'h4000, 16'h0200, 1'b0, 16};
    vecs[7]  = '{16'h0001, 16'h4000, 16'h0000, 1'b0, 16};
    vecs[8]  = '{16'h0003, 16'h4000, 16'h0002, 1'b0, 16};
    vecs[9]  = '{16'h0200, 16'h0400, 16'h3800, 1'b0, 16};
    vecs[10] = '{16'h4000, 16'h4000, 16'h3C00, 1'b0, 16};
    vecs[11] = '{16'h7E00, 16'h3C00, 16'h7FFF, 1'b0, 1};
    vecs[12] = '{16'h7C00, 16'hC000, 16'hFC00, 1'b0, 1};
    vecs[13] = '{16'h3C00, 16'hFC00, 16'h8000, 1'b0, 1};
    vecs[14] = '{16'h8000, 16'h3C00, 16'h8000, 1'b0, 1};
    vecs[15] = '{16'h7C00, 16'h0000, 16'h7C00, 1'b0, 1};
    vecs[16] = '{16'hBC00, 16'h8000, 16'h7C00, 1'b1, 1};
    vecs[17] = '{16'h4500, 16'h4200, 16'h3EAB, 1'b0, 16};
    vecs[18] = '{16'hC500, 16'h4000, 16'hC100, 1'b0, 16};
    vecs[19] = '{16'h3C00, 16'h7E00, 16'h7FFF, 1'b0, 1};

    repeat (3) @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", {16'd0, result}, 32'd0);
    check("reset dz", {31'd0, dz}, 32'd0);
    rst = 1'b0;

    for (int unsigned i = 0; i < 20; i++) begin
      run_vec(vecs[i], $sformatf("v%0d %h/%h", i, vecs[i].a, vecs[i].b));
    end

    // Operands keep changing while busy; only the first pair counts, and the
    // next pair is presented on the out_valid cycle.
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h4200;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    busy_ready = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) busy_ready++;
      a = 16'h4000 + 16'(i);
      b = 16'h3C00;
    end
    check("hs busy in_ready", busy_ready, 32'd0);
    check("hs first latency", lat, 32'd16);
    check("hs first result", {16'd0, result}, 32'h3555);
    check("hs ready on out_valid", {31'd0, in_ready}, 32'd1);
    a = 16'h4500;
    b = 16'h4200;
    @(posedge clk);
    wait_result(lat);
    check("hs second latency", lat, 32'd16);
    check("hs second result", {16'd0, result}, 32'h3EAB);

    // Reset in the 8th DIV cycle aborts the operation.
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h4200;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort result", {16'd0, result}, 32'd0);
    check("abort dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    stray = 0;
    for (int unsigned i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort no out_valid", stray, 32'd0);
    run_vec(vecs[10], "post-abort 4000/4000");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
